// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_LO,
        LD_HI,
        LD_DIV,
        CALC,
        OUT_Q,
        OUT_R
    } state_t;

    localparam state_t ST_RST   = IDLE;
    localparam logic   FLAG_RST = 1'b0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/restoring_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module restoring_step #(
    parameter int W = 5
) (
    input  logic [W-1:0] r,
    input  logic         nb,
    input  logic [W-1:0] d,
    output logic [W-1:0] r_nxt,
    output logic         q
);
    logic [W:0]   rs;
    logic [W-1:0] diff;

    assign rs    = {r, nb};
    assign q     = (rs >= {1'b0, d});
    // When q is set the difference is below d, so W bits hold it exactly.
    assign diff  = rs[W-1:0] - d;
    assign r_nxt = q ? diff : rs[W-1:0];

endmodule

// File: rtl/restoring_divider_seq.sv
// Sequential 2W/W restoring divider with word-serial load and Q/R readout.
// Optional signed mode when DIV_SIGNED_EN is defined.
module restoring_divider_seq
    import div_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef DIV_SIGNED_EN
    input  logic         sgn,
`endif
    input  logic [W-1:0] din,
    output logic [W-1:0] result,
    output logic         done,
    output logic         res_rem,
    output logic         busy,
    output logic         ovf_flag,
    output logic         dz_flag
);
    localparam int CW = clog2(W);

    state_t         state, state_n;
    logic [W-1:0]   lo, rem, dvs;
    logic [W-1:0]   rem_n, q_fin, q_out, r_out, dv_mag;
    logic [2*W-1:0] dd_mag;
    logic [CW-1:0]  cnt;
    logic           qb, exc, q_ovf;

    restoring_step #(.W(W)) u_step (
        .r     (rem),
        .nb    (lo[W-1]),
        .d     (dvs),
        .r_nxt (rem_n),
        .q     (qb)
    );

    assign q_fin = {lo[W-2:0], qb};

`ifdef DIV_SIGNED_EN
    localparam logic [W-1:0] Q_LIM  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] Q_MAXP = Q_LIM - 1'b1;

    logic sgn_q, neg_dd, neg_dv, q_neg, r_neg;

    assign neg_dd = sgn_q & rem[W-1];
    assign neg_dv = sgn_q & din[W-1];
    assign dd_mag = neg_dd ? -{rem, lo} : {rem, lo};
    assign dv_mag = neg_dv ? -din : din;
    assign q_out  = q_neg ? -q_fin : q_fin;
    assign r_out  = r_neg ? -rem : rem;
    assign q_ovf  = sgn_q & (q_fin > (q_neg ? Q_LIM : Q_MAXP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sgn_q <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE && start) begin
            sgn_q <= sgn;
        end else if (state == LD_DIV) begin
            q_neg <= neg_dd ^ neg_dv;
            r_neg <= neg_dd;
        end
    end
`else
    assign dd_mag = {rem, lo};
    assign dv_mag = din;
    assign q_out  = q_fin;
    assign r_out  = rem;
    assign q_ovf  = 1'b0;
`endif

    // A zero divisor also fails the magnitude test, so one compare covers both.
    assign exc = (dv_mag == '0) | (dd_mag[2*W-1:W] >= dv_mag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RST;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        res_rem = 1'b0;
        busy    = (state != IDLE);
        unique case (state)
            IDLE:    if (start) state_n = LD_LO;
            LD_LO:   state_n = LD_HI;
            LD_HI:   state_n = LD_DIV;
            LD_DIV:  state_n = exc ? OUT_Q : CALC;
            CALC:    if (cnt == '0) state_n = OUT_Q;
            OUT_Q: begin
                done    = 1'b1;
                state_n = OUT_R;
            end
            OUT_R: begin
                done    = 1'b1;
                res_rem = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo       <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            result   <= '0;
            ovf_flag <= FLAG_RST;
            dz_flag  <= FLAG_RST;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ovf_flag <= 1'b0;
                        dz_flag  <= 1'b0;
                    end
                end
                LD_LO: lo  <= din;
                LD_HI: rem <= din;
                LD_DIV: begin
                    lo       <= dd_mag[W-1:0];
                    rem      <= dd_mag[2*W-1:W];
                    dvs      <= dv_mag;
                    cnt      <= CW'(W - 1);
                    dz_flag  <= (din == '0);
                    ovf_flag <= exc;
                    if (exc) result <= '0;
                end
                CALC: begin
                    lo  <= q_fin;
                    rem <= rem_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        ovf_flag <= q_ovf;
                        result   <= q_ovf ? '0 : q_out;
                    end
                end
                OUT_Q:   result <= ovf_flag ? '0 : r_out;
                default: begin end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Scoreboard bench for restoring_divider_seq: directed and random
// operations scored against an arithmetic reference model.
module tb_restoring_divider_seq;
    localparam int W = 5;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        logic         dz;
        logic [7:0]   lat;
    } exp_t;

    logic         clk, rst, start;
    logic [W-1:0] din, result;
    logic         done, res_rem, busy, ovf_flag, dz_flag;
`ifdef DIV_SIGNED_EN
    logic         sgn;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   st_cyc = 0;
    exp_t sb[$];
    exp_t cur;
    bit   pend = 0;

    restoring_divider_seq #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef DIV_SIGNED_EN
        .sgn      (sgn),
`endif
        .din      (din),
        .result   (result),
        .done     (done),
        .res_rem  (res_rem),
        .busy     (busy),
        .ovf_flag (ovf_flag),
        .dz_flag  (dz_flag)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] lo, hi, dv,
                                   input bit s);
        exp_t   e;
        longint dd, dvv, a, b, qm, rm, qv, rv, lim;
        bit     neg;
        e     = '0;
        e.lat = 8'd3;
        dd    = longint'({hi, lo});
        dvv   = longint'(dv);
        lim   = longint'(1) << (W - 1);
        if (s && hi[W-1]) dd -= longint'(1) << (2 * W);
        if (s && dv[W-1]) dvv -= longint'(1) << W;
        if (dvv == 0) begin
            e.dz  = 1'b1;
            e.ovf = 1'b1;
        end else begin
            a  = (dd < 0) ? -dd : dd;
            b  = (dvv < 0) ? -dvv : dvv;
            qm = a / b;
            rm = a % b;
            if (qm >= (longint'(1) << W)) begin
                e.ovf = 1'b1;
            end else begin
                e.lat = 8'(W + 3);
                neg   = (dd < 0) != (dvv < 0);
                if (s && qm > (neg ? lim : lim - 1)) begin
                    e.ovf = 1'b1;
                end else begin
                    qv  = neg ? -qm : qm;
                    rv  = (dd < 0) ? -rm : rm;
                    e.q = qv[W-1:0];
                    e.r = rv[W-1:0];
                end
            end
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the quotient phase appears.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            pend = 0;
        end else if (pend) begin
            pend = 0;
            check("rem_phase", {done, res_rem}, 2'b11);
            check("remainder", result, cur.r);
        end else if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result=%0h res_rem=%0b",
                         result, res_rem);
            end else begin
                cur = sb.pop_front();
                check("quo_phase", res_rem, 0);
                check("quotient", result, cur.q);
                check("ovf_flag", ovf_flag, cur.ovf);
                check("dz_flag", dz_flag, cur.dz);
                check("latency", cyc - st_cyc, cur.lat);
                pend = 1;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 4 * W + 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy || done, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic load(input logic [W-1:0] lo, hi, dv, input bit s);
        start = 1;
        din   = '0;
`ifdef DIV_SIGNED_EN
        sgn   = s;
`endif
        @(negedge clk);
        st_cyc = cyc;
        check("busy_after_start", busy, 1);
        start = 0;
        din   = lo;
        @(negedge clk);
        din = hi;
        @(negedge clk);
        din = dv;
        @(negedge clk);
        din = '0;
    endtask

    // Entered at a negedge with the DUT idle, so start lands on the
    // first IDLE cycle after the previous operation.
    task automatic run_op(input logic [W-1:0] lo, hi, dv, input bit s,
                          input bit repulse);
        exp_t e;
        e = model(lo, hi, dv, s);
        sb.push_back(e);
        load(lo, hi, dv, s);
        if (repulse) begin
            @(negedge clk);
            start = 1;
            @(negedge clk);
            start = 0;
        end
        wait_idle();
        check("ovf_hold", ovf_flag, e.ovf);
        check("dz_hold", dz_flag, e.dz);
    endtask

    task automatic abort_op(input logic [W-1:0] lo, hi, dv);
        load(lo, hi, dv, 0);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        rst   = 0;
        #1;
        check("abort_outputs",
              {result, done, res_rem, busy, ovf_flag, dz_flag}, 0);
        @(negedge clk);
        rst = 1;
        repeat (3 * W) @(negedge clk);
        check("abort_quiet", busy || done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] lo, hi, dv;
        bit           s;
        rst   = 0;
        start = 0;
        din   = '0;
`ifdef DIV_SIGNED_EN
        sgn   = 0;
`endif
        repeat (2) @(negedge clk);
        check("reset_state",
              {result, done, res_rem, busy, ovf_flag, dz_flag}, 0);
        rst = 1;
        @(negedge clk);

        run_op(5'b01101, 5'b00001, 5'b01100, 0, 0);
        run_op(5'b01010, 5'b00001, 5'b00111, 0, 1);
        run_op(5'b10100, 5'b00110, 5'b00010, 0, 0);
        run_op(5'b10100, 5'b00101, 5'b00000, 0, 0);
        run_op(5'b11111, 5'b11110, 5'b11111, 0, 0);
        run_op(5'b00000, 5'b00000, 5'b00001, 0, 0);
        abort_op(5'b01101, 5'b00001, 5'b01100);
        run_op(5'b01101, 5'b00001, 5'b01100, 0, 0);
`ifdef DIV_SIGNED_EN
        run_op(5'b10011, 5'b11110, 5'b01100, 1, 0);
        run_op(5'b10011, 5'b11110, 5'b01100, 0, 0);
        run_op(5'b00000, 5'b11000, 5'b11111, 1, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            dv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            lo = W'($urandom);
            if (dv != '0 && $urandom_range(0, 1) == 1)
                hi = W'($urandom_range(0, int'(dv) - 1));
            else
                hi = W'($urandom);
`ifdef DIV_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 0;
`endif
            run_op(lo, hi, dv, s, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
